// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the radix-2 pipelined FFT slice.
//   - DW / NPT       : default word width and DFT frame length.
//   - dft4_state_t   : symbolic names of the frame sequencer states.
//   - sample_t       : signed real sample word.
package fft_pkg;

  localparam int DW  = 8;
  localparam int NPT = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2
  } dft4_state_t;

  typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/dft4_frame_buffer.sv
// dft4_frame_buffer
//   Holds the four samples of the frame being collected and checks the
//   optional end-of-frame marker.
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   wr_en           : a sample handshake happens this cycle
//   wr_data         : sample to store at the current count
//   wr_last         : end-of-frame marker that came with the sample
//   frame_full      : combinational, high on the handshake of the 4th sample
//   frame_err       : registered one-cycle pulse after an early end marker
//   x0..x3          : stored samples, in arrival order
module dft4_frame_buffer
  import fft_pkg::*;
#(
  parameter int DW = fft_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic          frame_full,
  output logic          frame_err,
  output logic [DW-1:0] x0,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3
);

  logic [DW-1:0] sbuf [4];
  logic [1:0]    cnt;

  // The 4th sample completes the frame regardless of wr_last; a marker on
  // that sample is legal and simply ignored.
  assign frame_full = wr_en && (cnt == 2'd3);

  assign x0 = sbuf[0];
  assign x1 = sbuf[1];
  assign x2 = sbuf[2];
  assign x3 = sbuf[3];

  // Sample storage and count. An end marker before the 4th sample drops the
  // partial frame by rewinding the count; stale entries are overwritten by
  // the next frame before they are ever read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sbuf[i] <= '0;
      end
      cnt       <= 2'd0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (wr_en) begin
        sbuf[cnt] <= wr_data;
        if (cnt == 2'd3) begin
          cnt <= 2'd0;
        end else if (wr_last) begin
          cnt       <= 2'd0;
          frame_err <= 1'b1;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/dft4_frame_sequencer.sv
// dft4_frame_sequencer
//   Sequences the 4-point DFT butterfly stage of the pipelined FFT: collects
//   four real samples, drives the even/odd terms into the external
//   combinational butterfly, captures its four results and streams them out.
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   s_valid/s_ready/s_data  : input sample stream, s_last optional marker
//   bf_in1..bf_in4          : E0=x0+x2, E1=x0-x2, O0=x1+x3, O1=x1-x3
//   bf_out1..bf_out4        : butterfly results, packed {re, im}
//   m_valid/m_ready/m_data  : output stream, m_index bin, m_last on bin 3
//   busy                    : high while loading or draining
//   frame_err               : one-cycle pulse on a short frame
module dft4_frame_sequencer
  import fft_pkg::*;
#(
  parameter int DW  = fft_pkg::DW,
  parameter int NPT = fft_pkg::NPT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic [DW-1:0] bf_in1,
  output logic [DW-1:0] bf_in2,
  output logic [DW-1:0] bf_in3,
  output logic [DW-1:0] bf_in4,
  input  logic [DW-1:0] bf_out1,
  input  logic [DW-1:0] bf_out2,
  input  logic [DW-1:0] bf_out3,
  input  logic [DW-1:0] bf_out4,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    m_index,
  output logic          m_last,
  output logic          busy,
  output logic          frame_err
);

  if (NPT != 4) begin : g_bad_npt
    $error("dft4_frame_sequencer: NPT must be 4");
  end

  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_LOAD    = LOAD;
  localparam logic [1:0] ST_DRAIN   = DRAIN;

  logic [1:0]    state;
  logic          load_phase;
  logic [1:0]    idx;
  logic [DW-1:0] res [4];
  logic          wr_en;
  logic          frame_full;
  logic [DW-1:0] x0, x1, x2, x3;

  // Input is only accepted while collecting, so s_ready is a pure function
  // of state and never of the downstream ready.
  assign s_ready = (state == ST_COLLECT);
  assign wr_en   = s_valid && s_ready;

  dft4_frame_buffer #(
    .DW(DW)
  ) u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (s_data),
    .wr_last   (s_last),
    .frame_full(frame_full),
    .frame_err (frame_err),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3)
  );

  // Output side is decoded from state; outside DRAIN the data word is forced
  // to zero so nothing stale is presented while m_valid is low.
  assign busy    = (state == ST_LOAD) || (state == ST_DRAIN);
  assign m_valid = (state == ST_DRAIN);
  assign m_index = idx;
  assign m_last  = (state == ST_DRAIN) && (idx == 2'd3);
  assign m_data  = (state == ST_DRAIN) ? res[idx] : '0;

  // Frame sequencer. LOAD spends two cycles: the first registers the E/O
  // terms from the buffer once the 4th sample has landed in it, the second
  // lets the butterfly settle on those registered terms and captures its
  // results. This places the first output two cycles after the 4th input
  // handshake and gives a 10-cycle frame period with m_ready held high.
  // The E/O sums are formed one bit wider and wrap back to DW bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_COLLECT;
      load_phase <= 1'b0;
      idx        <= 2'd0;
      bf_in1     <= '0;
      bf_in2     <= '0;
      bf_in3     <= '0;
      bf_in4     <= '0;
      for (int i = 0; i < 4; i++) begin
        res[i] <= '0;
      end
    end else begin
      case (state)
        ST_COLLECT: begin
          if (frame_full) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!load_phase) begin
            bf_in1     <= DW'({x0[DW-1], x0} + {x2[DW-1], x2});
            bf_in2     <= DW'({x0[DW-1], x0} - {x2[DW-1], x2});
            bf_in3     <= DW'({x1[DW-1], x1} + {x3[DW-1], x3});
            bf_in4     <= DW'({x1[DW-1], x1} - {x3[DW-1], x3});
            load_phase <= 1'b1;
          end else begin
            res[0]     <= bf_out1;
            res[1]     <= bf_out2;
            res[2]     <= bf_out3;
            res[3]     <= bf_out4;
            load_phase <= 1'b0;
            idx        <= 2'd0;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (m_ready) begin
            if (idx == 2'd3) begin
              idx   <= 2'd0;
              state <= ST_COLLECT;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: begin
          state      <= ST_COLLECT;
          load_phase <= 1'b0;
          idx        <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dft4_frame_sequencer.sv
// tb_dft4_frame_sequencer
//   Directed scenarios with a constant butterfly stub, followed by random
//   frames (with short frames and downstream stalls mixed in) where the stub
//   is a keyed function of bf_in so the E/O terms reach the output words.
module tb_dft4_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic [7:0] bf_in1, bf_in2, bf_in3, bf_in4;
  logic [7:0] bf_out1, bf_out2, bf_out3, bf_out4;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] m_index;
  logic       m_last;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int cyc    = 0;
  int hsCyc  = 0;
  bit stubMode = 1'b0;

  localparam logic [7:0] KEY1 = 8'h5A;
  localparam logic [7:0] KEY2 = 8'hC3;
  localparam logic [7:0] KEY3 = 8'h96;
  localparam logic [7:0] KEY4 = 8'h0F;

  dft4_frame_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .bf_in1   (bf_in1),
    .bf_in2   (bf_in2),
    .bf_in3   (bf_in3),
    .bf_in4   (bf_in4),
    .bf_out1  (bf_out1),
    .bf_out2  (bf_out2),
    .bf_out3  (bf_out3),
    .bf_out4  (bf_out4),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Butterfly stub: fixed words, or a keyed copy of the inputs.
  always_comb begin
    if (!stubMode) begin
      bf_out1 = 8'h11;
      bf_out2 = 8'h22;
      bf_out3 = 8'h33;
      bf_out4 = 8'h44;
    end else begin
      bf_out1 = bf_in1 ^ KEY1;
      bf_out2 = bf_in2 ^ KEY2;
      bf_out3 = bf_in3 ^ KEY3;
      bf_out4 = bf_in4 ^ KEY4;
    end
  end

  // Reference arithmetic: true signed sum/difference reduced modulo 256.
  function automatic logic [7:0] wrapSum(input logic [7:0] a, input logic [7:0] b, input bit sub);
    int s;
    s = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    return s[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One input handshake; returns at the falling edge after it.
  task automatic applyStimulus(input logic [7:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) checkOutput("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    hsCyc   = cyc;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic lastOn4);
    applyStimulus(a, 1'b0);
    applyStimulus(b, 1'b0);
    applyStimulus(c, 1'b0);
    applyStimulus(d, lastOn4);
    checkOutput("frame_err_legal", frame_err, 1'b0);
  endtask

  // Collects one output frame and checks words, indices, holds and latency.
  task automatic drainFrame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input logic [7:0] w3, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input int stallAt,
                            input int stallLen, input bit randReady);
    logic [7:0] expw [4];
    int n;
    int st;
    expw[0] = w0; expw[1] = w1; expw[2] = w2; expw[3] = w3;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!m_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!m_valid) checkOutput("m_valid_timeout", 32'd0, 32'd1);
      if (k == 0) begin
        checkOutput("latency", cyc - hsCyc, 32'd2);
        checkOutput("bf_in1", bf_in1, b1);
        checkOutput("bf_in2", bf_in2, b2);
        checkOutput("bf_in3", bf_in3, b3);
        checkOutput("bf_in4", bf_in4, b4);
      end
      checkOutput("m_data", m_data, expw[k]);
      checkOutput("m_index", m_index, k);
      checkOutput("m_last", m_last, (k == 3));
      checkOutput("s_ready_drain", s_ready, 1'b0);
      checkOutput("busy_drain", busy, 1'b1);
      if (k == stallAt) begin
        m_ready = 1'b0;
        repeat (stallLen) begin
          @(negedge clk);
          checkOutput("hold_data", m_data, expw[k]);
          checkOutput("hold_index", m_index, k);
          checkOutput("hold_valid", m_valid, 1'b1);
          checkOutput("hold_s_ready", s_ready, 1'b0);
        end
      end
      st = 0;
      while (randReady && st < 6 && $urandom_range(0, 2) == 0) begin
        m_ready = 1'b0;
        @(negedge clk);
        checkOutput("rand_hold_data", m_data, expw[k]);
        checkOutput("rand_hold_last", m_last, (k == 3));
        st++;
      end
      m_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("m_valid_after", m_valid, 1'b0);
    checkOutput("s_ready_after", s_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] x [4];
    logic [7:0] e0, e1, o0, o1;
    int n;
    int shortLen;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Reset held for three cycles.
    @(negedge clk);
    checkOutput("rst_s_ready", s_ready, 1'b1);
    checkOutput("rst_m_valid", m_valid, 1'b0);
    checkOutput("rst_m_data", m_data, 8'h00);
    checkOutput("rst_m_index", m_index, 2'd0);
    checkOutput("rst_m_last", m_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_frame_err", frame_err, 1'b0);
    checkOutput("rst_bf_in", {bf_in1, bf_in2, bf_in3, bf_in4}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_s_ready", s_ready, 1'b1);
    checkOutput("post_rst_m_valid", m_valid, 1'b0);

    // Basic frame.
    sendFrame(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    checkOutput("s_ready_load", s_ready, 1'b0);
    checkOutput("busy_load", busy, 1'b1);
    drainFrame(8'h11, 8'h22, 8'h33, 8'h44, 8'h04, 8'hFE, 8'h06, 8'hFE, -1, 0, 1'b0);

    // Downstream stall at bin 1, end marker on the 4th sample.
    sendFrame(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    drainFrame(8'h11, 8'h22, 8'h33, 8'h44, 8'h04, 8'hFE, 8'h06, 8'hFE, 1, 5, 1'b0);

    // Arithmetic wrap.
    sendFrame(8'd127, 8'd0, 8'd127, 8'd0, 1'b0);
    drainFrame(8'h11, 8'h22, 8'h33, 8'h44, 8'hFE, 8'h00, 8'h00, 8'h00, -1, 0, 1'b0);

    // Short frame then a good one.
    applyStimulus(8'd5, 1'b0);
    checkOutput("short_no_err_yet", frame_err, 1'b0);
    applyStimulus(8'd6, 1'b1);
    checkOutput("short_frame_err", frame_err, 1'b1);
    checkOutput("short_m_valid", m_valid, 1'b0);
    checkOutput("short_s_ready", s_ready, 1'b1);
    @(negedge clk);
    checkOutput("short_err_pulse", frame_err, 1'b0);
    sendFrame(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    drainFrame(8'h11, 8'h22, 8'h33, 8'h44, 8'h04, 8'hFE, 8'h06, 8'hFE, -1, 0, 1'b0);

    // Reset in the middle of a drain.
    sendFrame(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    n = 0;
    while (!(m_valid && m_index == 2'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_drain_reached", m_index, 2'd2);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_m_valid", m_valid, 1'b0);
    checkOutput("mid_rst_s_ready", s_ready, 1'b1);
    checkOutput("mid_rst_m_data", m_data, 8'h00);
    checkOutput("mid_rst_m_index", m_index, 2'd0);
    checkOutput("mid_rst_bf_in", {bf_in1, bf_in2, bf_in3, bf_in4}, 32'h0);
    sendFrame(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    drainFrame(8'h11, 8'h22, 8'h33, 8'h44, 8'h04, 8'hFE, 8'h06, 8'hFE, -1, 0, 1'b0);

    // Random frames against the arithmetic model.
    stubMode = 1'b1;
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        shortLen = $urandom_range(1, 3);
        for (int i = 0; i < shortLen; i++) begin
          applyStimulus(8'($urandom), (i == shortLen - 1));
        end
        checkOutput("rand_short_err", frame_err, 1'b1);
        @(negedge clk);
        checkOutput("rand_short_pulse", frame_err, 1'b0);
      end
      for (int i = 0; i < 4; i++) x[i] = 8'($urandom);
      e0 = wrapSum(x[0], x[2], 1'b0);
      e1 = wrapSum(x[0], x[2], 1'b1);
      o0 = wrapSum(x[1], x[3], 1'b0);
      o1 = wrapSum(x[1], x[3], 1'b1);
      sendFrame(x[0], x[1], x[2], x[3], 1'($urandom_range(0, 1)));
      drainFrame(e0 ^ KEY1, e1 ^ KEY2, o0 ^ KEY3, o1 ^ KEY4, e0, e1, o0, o1, -1, 0, 1'b1);
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
